spm_port_arbiter: RTL and testbench
===================================

Name: spm_port_arbiter

Overview:
- Shares the single NI scratch-pad memory (SPM) port among three requesters: the RX unit (write-only), the TX DMA read engine and the processor-side port.
- RX packets arrive on fixed TDM slots and cannot be stalled, so RX writes always win.
- TX and processor take the remaining cycles in round-robin order.
- Routes synchronous-read data back to the requester that issued the read, and counts cycles lost to RX.

Parameters:
- ADDR_W, 14, SPM word address width (64-bit words)
- CNT_W, 16, width of the saturating blocked-cycle counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rx_addr  in  ADDR_W  RX write address
- rx_en  in  2  RX half-word enables: bit0 = low 32 bits, bit1 = high 32 bits
- rx_wr  in  1  RX write strobe
- rx_wdata  in  64  RX write data
- tx_req  in  1  TX read request, held until tx_ack
- tx_addr  in  ADDR_W  TX read address
- tx_ack  out  1  TX request granted this cycle
- tx_rdata  out  64  TX read data
- tx_rvalid  out  1  tx_rdata valid
- cpu_req  in  1  processor request, held until cpu_ack
- cpu_wr  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  processor address
- cpu_en  in  2  processor half-word enables
- cpu_wdata  in  64  processor write data
- cpu_ack  out  1  processor request granted this cycle
- cpu_rdata  out  64  processor read data
- cpu_rvalid  out  1  cpu_rdata valid
- spm_addr  out  ADDR_W  SPM address
- spm_en  out  2  SPM half-word enables
- spm_wr  out  1  SPM write strobe
- spm_wdata  out  64  SPM write data
- spm_rdata  in  64  SPM read data, valid the cycle after a read access
- blocked_cnt  out  CNT_W  saturating count of cycles with a pending TX/CPU request denied because of RX

Behaviour:
- RX access is active when rx_en != 0. It drives the SPM that cycle with RX fields unchanged; tx_ack = cpu_ack = 0.
- Otherwise arbitration is round-robin between TX and CPU:
  - pointer rr (TX or CPU) gives priority to the side not granted last; rr updates only on a grant.
  - Sole requester is always granted.
- SPM outputs are combinational from the grant (zero-cycle latency):
  - TX grant: spm_en = 2'b11, spm_wr = 0.
  - CPU grant: spm_en = cpu_en, spm_wr = cpu_wr.
  - No access: spm_en = 0, spm_wr = 0, addr/wdata don't-care (drive 0).
- CPU grant with cpu_en = 0 is still acked but produces no SPM access (spm_en = 0) and no rvalid.
- Read return:
  - register rd_owner ∈ {NONE, TX, CPU} is set on a read grant.
  - Next cycle, spm_rdata is routed to the owner and its rvalid pulses for one cycle. The other side's rdata is 0.
  - Read-to-data latency is 1 cycle; back-to-back reads every cycle are supported.
- Writes: ack in the grant cycle; no rvalid.
- blocked_cnt increments when RX is active and (tx_req | cpu_req). It saturates at all-ones and never wraps.
- Simultaneous RX + TX + CPU request: RX wins, counter +1, rr unchanged. The next free cycle grants the rr-preferred side.
- Reset values: rr = TX, rd_owner = NONE, tx_rvalid = cpu_rvalid = 0, blocked_cnt = 0. Combinational outputs follow their inputs; with rx_en = 0 and no requests, spm_en = 0.
- Reset mid-read: a pending rd_owner is cleared, and no rvalid is issued the cycle after reset.
- Requester contract (checked by assertion, not handled by design): a held request keeps address/data stable until ack.

Decomposition:
- Shared package holds:
  - owner enum (NONE/TX/CPU);
  - SPM_HALF_LO / SPM_HALF_HI enable constants;
  - SPM word width constant 64.
- One natural sub-module: rr_arb2, a two-requester round-robin arbiter with pointer register and grant outputs.
- The rdata routing register and counter stay in the top level.

Test Plan:
- TX read only, tx_addr = 0x010, spm_rdata = 0xDEADBEEF_00000001 next cycle -> tx_ack = 1 at cycle 0, spm_en = 11, spm_wr = 0, tx_rvalid = 1 with that data at cycle 1, cpu_rvalid = 0.
- RX write (addr 0x020, en = 01) in the same cycle as tx_req and cpu_req -> spm_addr = 0x020, spm_wr = 1, no acks, blocked_cnt 0 -> 1. Next cycle (rx_en = 0): TX granted (rr reset value); following cycle: CPU granted.
- TX and CPU requesting continuously for 6 cycles, no RX -> acks alternate TX, CPU, TX, CPU, TX, CPU; rvalids follow each grant by exactly 1 cycle with correct routing.
- CPU write addr 0x3FFF, en = 10, wdata = 0x1234…, then immediate CPU read -> write acked with spm_wr = 1, en = 10; read acked next cycle, cpu_rvalid one cycle later, no tx_rvalid.
- Force blocked_cnt to 0xFFFE, then 3 blocked cycles -> 0xFFFF, held at 0xFFFF.
- TX read granted, reset asserted the following cycle -> tx_rvalid = 0 that cycle; all registers at reset values; first post-reset grant goes to TX.

Source files
------------

// File: rtl/spm_port_arbiter_pkg.sv
// rtl/spm_port_arbiter_pkg.sv - shared types and constants for the SPM port arbiter
package spm_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_TX   = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

    localparam logic [1:0] SPM_HALF_LO = 2'b01;
    localparam logic [1:0] SPM_HALF_HI = 2'b10;
    localparam int         SPM_DATA_W  = 64;

endpackage

// File: rtl/spm_port_arbiter_rr_arb2.sv
// rtl/spm_port_arbiter_rr_arb2.sv - two-requester round-robin arbiter (TX vs CPU)
module rr_arb2
    import spm_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic hold,
    input  logic req_tx,
    input  logic req_cpu,
    output logic gnt_tx,
    output logic gnt_cpu
);

    owner_e rr_q;
    owner_e rr_d;

    // While held (RX owns the port) nobody is granted and the pointer stays put.
    always_comb begin
        gnt_tx  = !hold && req_tx  && (!req_cpu || (rr_q == OWN_TX));
        gnt_cpu = !hold && req_cpu && (!req_tx  || (rr_q == OWN_CPU));
        rr_d    = rr_q;
        if (gnt_tx) begin
            rr_d = OWN_CPU;
        end else if (gnt_cpu) begin
            rr_d = OWN_TX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= OWN_TX;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/spm_port_arbiter.sv
// rtl/spm_port_arbiter.sv - shares the NI scratch-pad port between RX, TX DMA and CPU
module spm_port_arbiter
    import spm_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     rx_addr,
    input  logic [1:0]            rx_en,
    input  logic                  rx_wr,
    input  logic [SPM_DATA_W-1:0] rx_wdata,
    input  logic                  tx_req,
    input  logic [ADDR_W-1:0]     tx_addr,
    output logic                  tx_ack,
    output logic [SPM_DATA_W-1:0] tx_rdata,
    output logic                  tx_rvalid,
    input  logic                  cpu_req,
    input  logic                  cpu_wr,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [1:0]            cpu_en,
    input  logic [SPM_DATA_W-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [SPM_DATA_W-1:0] cpu_rdata,
    output logic                  cpu_rvalid,
    output logic [ADDR_W-1:0]     spm_addr,
    output logic [1:0]            spm_en,
    output logic                  spm_wr,
    output logic [SPM_DATA_W-1:0] spm_wdata,
    input  logic [SPM_DATA_W-1:0] spm_rdata,
    output logic [CNT_W-1:0]      blocked_cnt
);

    logic             rx_active;
    logic             gnt_tx;
    logic             gnt_cpu;
    owner_e           rd_owner_q;
    owner_e           rd_owner_d;
    logic [CNT_W-1:0] blocked_cnt_q;
    logic [CNT_W-1:0] blocked_cnt_d;

    assign rx_active = |rx_en;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .hold    (rx_active),
        .req_tx  (tx_req),
        .req_cpu (cpu_req),
        .gnt_tx  (gnt_tx),
        .gnt_cpu (gnt_cpu)
    );

    assign tx_ack  = gnt_tx;
    assign cpu_ack = gnt_cpu;

    always_comb begin
        spm_addr  = '0;
        spm_en    = 2'b00;
        spm_wr    = 1'b0;
        spm_wdata = '0;
        if (rx_active) begin
            spm_addr  = rx_addr;
            spm_en    = rx_en;
            spm_wr    = rx_wr;
            spm_wdata = rx_wdata;
        end else if (gnt_tx) begin
            spm_addr  = tx_addr;
            spm_en    = SPM_HALF_HI | SPM_HALF_LO;
        end else if (gnt_cpu && (cpu_en != 2'b00)) begin
            spm_addr  = cpu_addr;
            spm_en    = cpu_en;
            spm_wr    = cpu_wr;
            spm_wdata = cpu_wdata;
        end
    end

    // A CPU grant with no enables is acked but never touches the SPM, so it owns no read.
    always_comb begin
        rd_owner_d = OWN_NONE;
        if (gnt_tx) begin
            rd_owner_d = OWN_TX;
        end else if (gnt_cpu && !cpu_wr && (cpu_en != 2'b00)) begin
            rd_owner_d = OWN_CPU;
        end
    end

    always_comb begin
        blocked_cnt_d = blocked_cnt_q;
        if (rx_active && (tx_req || cpu_req) && (blocked_cnt_q != {CNT_W{1'b1}})) begin
            blocked_cnt_d = blocked_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_owner_q    <= OWN_NONE;
            blocked_cnt_q <= '0;
        end else begin
            rd_owner_q    <= rd_owner_d;
            blocked_cnt_q <= blocked_cnt_d;
        end
    end

    // Read data returned while reset is held belongs to an access being abandoned.
    assign tx_rvalid   = !reset && (rd_owner_q == OWN_TX);
    assign cpu_rvalid  = !reset && (rd_owner_q == OWN_CPU);
    assign tx_rdata    = tx_rvalid  ? spm_rdata : '0;
    assign cpu_rdata   = cpu_rvalid ? spm_rdata : '0;
    assign blocked_cnt = blocked_cnt_q;

    a_tx_stable: assert property (@(posedge clk) disable iff (reset)
        (tx_req && !tx_ack) |=> $stable(tx_addr));

    a_cpu_stable: assert property (@(posedge clk) disable iff (reset)
        (cpu_req && !cpu_ack) |=> ($stable(cpu_addr) && $stable(cpu_wr)
                                   && $stable(cpu_en) && $stable(cpu_wdata)));

endmodule

// File: tb/tb_spm_port_arbiter.sv
// tb/tb_spm_port_arbiter.sv - directed self-checking bench for spm_port_arbiter
module tb_spm_port_arbiter;

    localparam int ADDR_W = 14;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] rx_addr;
    logic [1:0]        rx_en;
    logic              rx_wr;
    logic [63:0]       rx_wdata;
    logic              tx_req;
    logic [ADDR_W-1:0] tx_addr;
    logic              tx_ack;
    logic [63:0]       tx_rdata;
    logic              tx_rvalid;
    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [1:0]        cpu_en;
    logic [63:0]       cpu_wdata;
    logic              cpu_ack;
    logic [63:0]       cpu_rdata;
    logic              cpu_rvalid;
    logic [ADDR_W-1:0] spm_addr;
    logic [1:0]        spm_en;
    logic              spm_wr;
    logic [63:0]       spm_wdata;
    logic [63:0]       spm_rdata;
    logic [CNT_W-1:0]  blocked_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spm_port_arbiter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .rx_addr(rx_addr), .rx_en(rx_en), .rx_wr(rx_wr), .rx_wdata(rx_wdata),
        .tx_req(tx_req), .tx_addr(tx_addr), .tx_ack(tx_ack),
        .tx_rdata(tx_rdata), .tx_rvalid(tx_rvalid),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_en(cpu_en),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .spm_addr(spm_addr), .spm_en(spm_en), .spm_wr(spm_wr), .spm_wdata(spm_wdata),
        .spm_rdata(spm_rdata), .blocked_cnt(blocked_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        rx_addr = '0; rx_en = 2'b00; rx_wr = 1'b0; rx_wdata = '0;
        tx_req = 1'b0; tx_addr = '0;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_en = 2'b00; cpu_wdata = '0;
        spm_rdata = '0;
        cyc(); cyc();
        mid();
        chk("rst_blocked", 64'(blocked_cnt), 64'h0);
        chk("rst_tx_rvalid", 64'(tx_rvalid), 64'h0);
        chk("rst_cpu_rvalid", 64'(cpu_rvalid), 64'h0);
        chk("rst_spm_en", 64'(spm_en), 64'h0);

        // RX write collides with both requesters
        cyc();
        reset = 1'b0;
        rx_addr = 14'h020; rx_en = 2'b01; rx_wr = 1'b1; rx_wdata = 64'h0000_0000_CAFE_F00D;
        tx_req = 1'b1; tx_addr = 14'h100;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 14'h200; cpu_en = 2'b11;
        mid();
        chk("rx_spm_addr", 64'(spm_addr), 64'h020);
        chk("rx_spm_wr", 64'(spm_wr), 64'h1);
        chk("rx_spm_en", 64'(spm_en), 64'h1);
        chk("rx_spm_wdata", spm_wdata, 64'h0000_0000_CAFE_F00D);
        chk("rx_tx_ack", 64'(tx_ack), 64'h0);
        chk("rx_cpu_ack", 64'(cpu_ack), 64'h0);
        chk("rx_blocked_before", 64'(blocked_cnt), 64'h0);
        cyc();
        rx_en = 2'b00; rx_wr = 1'b0;
        mid();
        chk("rx_blocked_after", 64'(blocked_cnt), 64'h1);
        chk("free1_tx_ack", 64'(tx_ack), 64'h1);
        chk("free1_cpu_ack", 64'(cpu_ack), 64'h0);
        chk("free1_spm_addr", 64'(spm_addr), 64'h100);
        cyc();
        tx_req = 1'b0;
        spm_rdata = 64'h1111_2222_3333_4444;
        mid();
        chk("free2_cpu_ack", 64'(cpu_ack), 64'h1);
        chk("free2_spm_addr", 64'(spm_addr), 64'h200);
        chk("free2_spm_en", 64'(spm_en), 64'h3);
        chk("free2_tx_rvalid", 64'(tx_rvalid), 64'h1);
        chk("free2_tx_rdata", tx_rdata, 64'h1111_2222_3333_4444);
        cyc();
        cpu_req = 1'b0;
        spm_rdata = 64'h5555_6666_7777_8888;
        mid();
        chk("free3_cpu_rvalid", 64'(cpu_rvalid), 64'h1);
        chk("free3_cpu_rdata", cpu_rdata, 64'h5555_6666_7777_8888);
        chk("free3_tx_rvalid", 64'(tx_rvalid), 64'h0);
        chk("free3_tx_rdata", tx_rdata, 64'h0);

        // TX read alone
        cyc();
        tx_req = 1'b1; tx_addr = 14'h010;
        mid();
        chk("t1_tx_ack", 64'(tx_ack), 64'h1);
        chk("t1_spm_en", 64'(spm_en), 64'h3);
        chk("t1_spm_wr", 64'(spm_wr), 64'h0);
        chk("t1_spm_addr", 64'(spm_addr), 64'h010);
        cyc();
        tx_req = 1'b0;
        spm_rdata = 64'hDEADBEEF_00000001;
        mid();
        chk("t1_tx_rvalid", 64'(tx_rvalid), 64'h1);
        chk("t1_tx_rdata", tx_rdata, 64'hDEADBEEF_00000001);
        chk("t1_cpu_rvalid", 64'(cpu_rvalid), 64'h0);

        // CPU write at top address, then CPU read
        cyc();
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 14'h3FFF; cpu_en = 2'b10;
        cpu_wdata = 64'h1234_5678_9ABC_DEF0;
        mid();
        chk("t4w_cpu_ack", 64'(cpu_ack), 64'h1);
        chk("t4w_spm_wr", 64'(spm_wr), 64'h1);
        chk("t4w_spm_en", 64'(spm_en), 64'h2);
        chk("t4w_spm_addr", 64'(spm_addr), 64'h3FFF);
        chk("t4w_spm_wdata", spm_wdata, 64'h1234_5678_9ABC_DEF0);
        cyc();
        cpu_wr = 1'b0; cpu_en = 2'b11;
        mid();
        chk("t4r_cpu_ack", 64'(cpu_ack), 64'h1);
        chk("t4r_spm_wr", 64'(spm_wr), 64'h0);
        chk("t4r_no_rvalid_after_wr", 64'(cpu_rvalid), 64'h0);
        cyc();
        cpu_req = 1'b0;
        spm_rdata = 64'h0BAD_F00D_0000_3FFF;
        mid();
        chk("t4r_cpu_rvalid", 64'(cpu_rvalid), 64'h1);
        chk("t4r_cpu_rdata", cpu_rdata, 64'h0BAD_F00D_0000_3FFF);
        chk("t4r_tx_rvalid", 64'(tx_rvalid), 64'h0);

        // Continuous contention: strict alternation starting with TX
        for (int i = 0; i < 6; i++) begin
            cyc();
            tx_req = 1'b1; tx_addr = 14'h040;
            cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 14'h080; cpu_en = 2'b11;
            spm_rdata = 64'hA000 + 64'(i);
            mid();
            chk($sformatf("rr%0d_tx_ack", i), 64'(tx_ack), 64'((i % 2) == 0));
            chk($sformatf("rr%0d_cpu_ack", i), 64'(cpu_ack), 64'((i % 2) == 1));
            if (i > 0) begin
                chk($sformatf("rr%0d_tx_rvalid", i), 64'(tx_rvalid), 64'((i % 2) == 1));
                chk($sformatf("rr%0d_cpu_rvalid", i), 64'(cpu_rvalid), 64'((i % 2) == 0));
                chk($sformatf("rr%0d_rdata", i), ((i % 2) == 1) ? tx_rdata : cpu_rdata,
                    64'hA000 + 64'(i));
            end
        end
        cyc();
        tx_req = 1'b0; cpu_req = 1'b0;
        spm_rdata = 64'hA006;
        mid();
        chk("rr6_cpu_rvalid", 64'(cpu_rvalid), 64'h1);
        chk("rr6_cpu_rdata", cpu_rdata, 64'hA006);
        chk("rr6_tx_rvalid", 64'(tx_rvalid), 64'h0);

        // Blocked counter saturation
        cyc();
        rx_en = 2'b11; rx_wr = 1'b1; rx_addr = 14'h001;
        tx_req = 1'b1; tx_addr = 14'h077;
        repeat (16'hFFFD) @(posedge clk);
        #1;
        chk("sat_fffe", 64'(blocked_cnt), 64'hFFFE);
        chk("sat_tx_ack", 64'(tx_ack), 64'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("sat_ffff_%0d", i), 64'(blocked_cnt), 64'hFFFF);
        end
        rx_en = 2'b00; rx_wr = 1'b0;
        mid();
        chk("sat_release_tx_ack", 64'(tx_ack), 64'h1);

        // Reset lands right after a TX read grant
        cyc();
        tx_req = 1'b1; tx_addr = 14'h055;
        mid();
        chk("rst_mid_tx_ack", 64'(tx_ack), 64'h1);
        cyc();
        reset = 1'b1; tx_req = 1'b0;
        spm_rdata = 64'hFFFF_0000_FFFF_0000;
        mid();
        chk("rst_mid_tx_rvalid", 64'(tx_rvalid), 64'h0);
        cyc();
        reset = 1'b0;
        tx_req = 1'b1; tx_addr = 14'h066;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 14'h099; cpu_en = 2'b11;
        mid();
        chk("post_rst_blocked", 64'(blocked_cnt), 64'h0);
        chk("post_rst_tx_rvalid", 64'(tx_rvalid), 64'h0);
        chk("post_rst_cpu_rvalid", 64'(cpu_rvalid), 64'h0);
        chk("post_rst_tx_ack", 64'(tx_ack), 64'h1);
        chk("post_rst_cpu_ack", 64'(cpu_ack), 64'h0);
        cyc();
        tx_req = 1'b0; cpu_req = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
